// File: rtl/pcomp.sv
// Position compare: emits pulses as a position stream crosses
// programmed start/end edges, either from START/STEP/WIDTH or a table.
module pcomp (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [31:0] posn_i,
  input  logic [31:0] START,
  input  logic [31:0] STEP,
  input  logic [31:0] WIDTH,
  input  logic [31:0] NUM,
  input  logic        RELATIVE,
  input  logic        DIR,
  input  logic [31:0] DELTAP,
  input  logic        USE_TABLE,
  input  logic [63:0] table_posn_i,
  output logic        act_o,
  output logic        pulse_o,
  output logic [31:0] err_o
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ARM,
    WAIT_START,
    PULSE_ON,
    ERROR
  } state_e;

  state_e      state_q, state_d;
  logic        enable_q;
  logic [31:0] origin_q, origin_d;
  logic [31:0] start_q, start_d;
  logic [31:0] end_q, end_d;
  logic [31:0] count_q, count_d;
  logic [31:0] num_q, num_d;
  logic [31:0] deltap_q, deltap_d;
  logic        dir_q, dir_d;
  logic        tbl_q, tbl_d;
  logic        act_q, act_d;
  logic        pulse_q, pulse_d;
  logic        err_q, err_d;

  logic        rise;
  logic [31:0] org_new, st_new, en_new;
  logic [31:0] st_adv, en_adv;
  logic        arm;

  function automatic logic reached(
    input logic [31:0] p,
    input logic [31:0] x,
    input logic        dir
  );
    if (dir) return $signed(p) <= $signed(x);
    return $signed(p) >= $signed(x);
  endfunction

  always_comb begin
    rise    = enable_i & ~enable_q;
    org_new = RELATIVE ? posn_i : 32'd0;
    st_new  = org_new + (USE_TABLE ? table_posn_i[31:0] : START);
    if (USE_TABLE)
      en_new = org_new + table_posn_i[63:32];
    else if (DIR)
      en_new = st_new - WIDTH;
    else
      en_new = st_new + WIDTH;

    if (tbl_q)
      st_adv = origin_q + table_posn_i[31:0];
    else if (dir_q)
      st_adv = start_q - STEP;
    else
      st_adv = start_q + STEP;
    if (tbl_q)
      en_adv = origin_q + table_posn_i[63:32];
    else if (dir_q)
      en_adv = st_adv - WIDTH;
    else
      en_adv = st_adv + WIDTH;

    // Zero arming distance means "not yet at start" rather than "at start".
    if (deltap_q == 32'd0)
      arm = !reached(posn_i, start_q, dir_q);
    else if (dir_q)
      arm = $signed(posn_i) >= $signed(start_q + deltap_q);
    else
      arm = $signed(posn_i) <= $signed(start_q - deltap_q);
  end

  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    start_d  = start_q;
    end_d    = end_q;
    count_d  = count_q;
    num_d    = num_q;
    deltap_d = deltap_q;
    dir_d    = dir_q;
    tbl_d    = tbl_q;
    act_d    = act_q;
    pulse_d  = pulse_q;
    err_d    = err_q;

    if (state_q != IDLE && !enable_i) begin
      state_d = IDLE;
      pulse_d = 1'b0;
      act_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            origin_d = org_new;
            start_d  = st_new;
            end_d    = en_new;
            count_d  = 32'd0;
            num_d    = NUM;
            deltap_d = DELTAP;
            dir_d    = DIR;
            tbl_d    = USE_TABLE;
            err_d    = 1'b0;
            act_d    = 1'b1;
            state_d  = WAIT_ARM;
          end
        end
        WAIT_ARM: begin
          if (arm) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (reached(posn_i, start_q, dir_q)) begin
            if (reached(posn_i, end_q, dir_q)) begin
              err_d   = 1'b1;
              act_d   = 1'b0;
              pulse_d = 1'b0;
              state_d = ERROR;
            end else begin
              pulse_d = 1'b1;
              state_d = PULSE_ON;
            end
          end
        end
        PULSE_ON: begin
          if (reached(posn_i, end_q, dir_q)) begin
            pulse_d = 1'b0;
            count_d = count_q + 32'd1;
            if (num_q != 32'd0 && count_q + 32'd1 == num_q) begin
              act_d   = 1'b0;
              state_d = IDLE;
            end else begin
              start_d = st_adv;
              end_d   = en_adv;
              state_d = WAIT_START;
            end
          end
        end
        ERROR: begin
          pulse_d = 1'b0;
          act_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      // Treat enable as already high so a level held through reset cannot arm.
      enable_q <= 1'b1;
      origin_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
      count_q  <= '0;
      num_q    <= '0;
      deltap_q <= '0;
      dir_q    <= 1'b0;
      tbl_q    <= 1'b0;
      act_q    <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_i;
      origin_q <= origin_d;
      start_q  <= start_d;
      end_q    <= end_d;
      count_q  <= count_d;
      num_q    <= num_d;
      deltap_q <= deltap_d;
      dir_q    <= dir_d;
      tbl_q    <= tbl_d;
      act_q    <= act_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign act_o   = act_q;
  assign pulse_o = pulse_q;
  assign err_o   = {31'd0, err_q};

endmodule

// File: tb/tb_pcomp.sv
// Directed bench for pcomp: expected outputs are queued with each
// position sample and compared one clock later.
module tb_pcomp;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [31:0] posn_i;
  logic [31:0] START, STEP, WIDTH, NUM, DELTAP;
  logic        RELATIVE, DIR, USE_TABLE;
  logic [63:0] table_posn_i;
  logic        act_o, pulse_o;
  logic [31:0] err_o;

  typedef struct packed {
    logic        p;
    logic        a;
    logic [31:0] e;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  pcomp dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .posn_i(posn_i),
    .START(START),
    .STEP(STEP),
    .WIDTH(WIDTH),
    .NUM(NUM),
    .RELATIVE(RELATIVE),
    .DIR(DIR),
    .DELTAP(DELTAP),
    .USE_TABLE(USE_TABLE),
    .table_posn_i(table_posn_i),
    .act_o(act_o),
    .pulse_o(pulse_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push(input logic ep, input logic ea,
                      input logic [31:0] ee, input string tag);
    exp_t x;
    x.p = ep;
    x.a = ea;
    x.e = ee;
    sbq.push_back(x);
    tagq.push_back(tag);
  endtask

  task automatic check();
    exp_t  x, o;
    string t;
    x = sbq.pop_front();
    t = tagq.pop_front();
    o.p = pulse_o;
    o.a = act_o;
    o.e = err_o;
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: pulse/act/err got %0b/%0b/%0d want %0b/%0b/%0d",
             t, o.p, o.a, o.e, x.p, x.a, x.e);
    end
  endtask

  task automatic drive(input int p, input logic en, input logic ep,
                       input logic ea, input logic [31:0] ee,
                       input string tag);
    @(negedge clk_i);
    posn_i   = p;
    enable_i = en;
    push(ep, ea, ee, tag);
    @(posedge clk_i);
    #1;
    check();
  endtask

  task automatic cfg(input int st, input int stp, input int w,
                     input int n, input logic rel, input logic d,
                     input int dp);
    START    = st;
    STEP     = stp;
    WIDTH    = w;
    NUM      = n;
    RELATIVE = rel;
    DIR      = d;
    DELTAP   = dp;
  endtask

  initial begin
    reset_i      = 1'b1;
    enable_i     = 1'b1;
    posn_i       = '0;
    USE_TABLE    = 1'b0;
    table_posn_i = '0;
    cfg(100, 50, 10, 3, 1'b0, 1'b0, 0);
    #2 reset_i = 1'b0;
    #1;
    push(1'b0, 1'b0, 32'd0, "reset");
    check();
    #10 reset_i = 1'b1;

    // enable high across reset release must not start a run
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, 1'b0, 0, "no_start");
    drive(0, 1'b0, 1'b0, 1'b0, 0, "idle");

    // basic ramp, three pulses
    for (int p = 0; p <= 300; p++)
      drive(p, 1'b1,
            (p >= 100 && p <= 109) || (p >= 150 && p <= 159) ||
            (p >= 200 && p <= 209),
            p <= 209, 0, "ramp3");
    drive(300, 1'b0, 1'b0, 1'b0, 0, "drop1");

    // relative start; START changed mid-run is ignored
    cfg(20, 50, 5, 1, 1'b1, 1'b0, 0);
    drive(1000, 1'b1, 1'b0, 1'b1, 0, "rel_rise");
    START = 32'd999;
    for (int p = 1001; p <= 1030; p++)
      drive(p, 1'b1, p >= 1020 && p <= 1024, p <= 1024, 0, "rel");
    drive(1030, 1'b0, 1'b0, 1'b0, 0, "drop2");

    // negative direction
    cfg(-100, 20, 5, 2, 1'b0, 1'b1, 0);
    for (int p = 0; p >= -140; p--)
      drive(p, 1'b1,
            (p <= -100 && p >= -104) || (p <= -120 && p >= -124),
            p > -125, 0, "neg");
    drive(-140, 1'b0, 1'b0, 1'b0, 0, "drop3");

    // arming distance
    cfg(100, 50, 10, 1, 1'b0, 1'b0, 10);
    for (int p = 95; p <= 105; p++)
      drive(p, 1'b1, 1'b0, 1'b1, 0, "unarmed");
    for (int p = 104; p >= 85; p--)
      drive(p, 1'b1, 1'b0, 1'b1, 0, "dip");
    for (int p = 86; p <= 115; p++)
      drive(p, 1'b1, p >= 100 && p <= 109, p <= 109, 0, "armed");
    drive(115, 1'b0, 1'b0, 1'b0, 0, "drop4");

    // skipped pulse -> error
    cfg(100, 50, 3, 0, 1'b0, 1'b0, 0);
    for (int p = 90; p <= 99; p++)
      drive(p, 1'b1, 1'b0, 1'b1, 0, "pre_skip");
    drive(110, 1'b1, 1'b0, 1'b0, 1, "skip");
    drive(111, 1'b1, 1'b0, 1'b0, 1, "err_held");
    drive(112, 1'b1, 1'b0, 1'b0, 1, "err_held");
    drive(112, 1'b0, 1'b0, 1'b0, 1, "err_drop");
    drive(0, 1'b1, 1'b0, 1'b1, 0, "err_clr");
    drive(0, 1'b0, 1'b0, 1'b0, 0, "drop5");

    // table-driven edges; STEP/WIDTH ignored
    USE_TABLE    = 1'b1;
    cfg(0, 5, 1, 2, 1'b0, 1'b0, 0);
    table_posn_i = {32'd40, 32'd30};
    drive(0, 1'b1, 1'b0, 1'b1, 0, "tbl_rise");
    table_posn_i = {32'd70, 32'd60};
    for (int p = 1; p <= 80; p++)
      drive(p, 1'b1,
            (p >= 30 && p <= 39) || (p >= 60 && p <= 69),
            p <= 69, 0, "tbl");
    drive(80, 1'b0, 1'b0, 1'b0, 0, "drop6");
    USE_TABLE = 1'b0;

    // enable dropped mid-pulse
    cfg(100, 50, 10, 3, 1'b0, 1'b0, 0);
    for (int p = 95; p <= 103; p++)
      drive(p, 1'b1, p >= 100, 1'b1, 0, "pre_abort");
    drive(104, 1'b0, 1'b0, 1'b0, 0, "abort");
    drive(105, 1'b0, 1'b0, 1'b0, 0, "aborted");

    // reset mid-pulse
    for (int p = 95; p <= 102; p++)
      drive(p, 1'b1, p >= 100, 1'b1, 0, "pre_rst");
    #2 reset_i = 1'b0;
    #1;
    push(1'b0, 1'b0, 32'd0, "rst_async");
    check();
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(103, 1'b1, 1'b0, 1'b0, 0, "post_rst");
    drive(104, 1'b1, 1'b0, 1'b0, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcomp.md
PCOMP -- requirements
Module: pcomp

Interface
REQ-001 Parameters: none; all configuration arrives on register ports, sampled every clock.
REQ-002 clk_i  in  1  single system clock; all logic on rising edge.
REQ-003 reset_i  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 enable_i  in  1  run gate; rising edge arms a compare sequence, low aborts it.
REQ-005 posn_i  in  32  signed position sample, one per clock.
REQ-006 START  in  32  signed first pulse position (absolute, or offset when RELATIVE=1).
REQ-007 STEP  in  32  unsigned distance between successive pulse starts.
REQ-008 WIDTH  in  32  unsigned pulse width in position units.
REQ-009 NUM  in  32  pulses per run; 0 = unlimited.
REQ-010 RELATIVE  in  1  1 = START/table positions offset by posn_i latched at enable rise.
REQ-011 DIR  in  1  0 = positive (increasing) travel, 1 = negative travel.
REQ-012 DELTAP  in  32  unsigned pre-start arming distance.
REQ-013 USE_TABLE  in  1  1 = pulse edges taken from table_posn_i instead of START/STEP/WIDTH.
REQ-014 table_posn_i  in  64  [31:0] signed pulse start, [63:32] signed pulse end, per pulse.
REQ-015 act_o  out  1  run active.
REQ-016 pulse_o  out  1  compare output pulse.
REQ-017 err_o  out  32  error code; 0 none, 1 position skipped a whole pulse in one sample; bits 31:1 are 0.

Function
REQ-018 Arithmetic: positions signed 32-bit two's complement, wrap-around on add; compares signed.
REQ-019 Direction: DIR=0 "reached X" means posn_i >= X, edges advance +STEP, end = start+WIDTH; DIR=1 means posn_i <= X, edges advance -STEP, end = start-WIDTH.
REQ-020 States: IDLE, WAIT_ARM, WAIT_START, PULSE_ON, ERROR.
REQ-021 IDLE: enable_i 0->1 latches origin = RELATIVE ? posn_i : 0, start = origin+START (or origin+table[31:0]), end per REQ-019 (or origin+table[63:32]), count=0, err_o=0, act_o=1, -> WAIT_ARM.
REQ-022 WAIT_ARM: leaves to WAIT_START once posn_i is DELTAP before start (DIR=0: posn_i <= start-DELTAP; DIR=1: posn_i >= start+DELTAP); DELTAP=0 arms when posn_i has not yet reached start.
REQ-023 WAIT_START: reached start and not reached end -> pulse_o=1, -> PULSE_ON; reached start and end in same sample -> ERROR.
REQ-024 PULSE_ON: reached end -> pulse_o=0, count+1; if NUM/=0 and count+1=NUM -> act_o=0, IDLE; else start += ±STEP (or load next table entry), recompute end, -> WAIT_START.
REQ-025 ERROR: pulse_o=0, act_o=0, err_o=1 held until next enable rise; -> IDLE.
REQ-026 Latency: pulse_o/act_o/err_o registered, change one clock after the posn_i sample that causes them.
REQ-027 enable_i low in any non-IDLE state: next clock pulse_o=0, act_o=0, IDLE, err_o unchanged; no pulse is counted.
REQ-028 enable_i held high after completion does not restart; a fresh 0->1 edge is required.
REQ-029 Register ports except posn_i/enable_i/table_posn_i are used only when latched (enable rise) or at pulse advance; changes mid-pulse do not alter current edges.
REQ-030 USE_TABLE=1: STEP/WIDTH ignored; table_posn_i sampled on enable rise and on each pulse end.

Reset
REQ-031 reset_i=0 asynchronously forces IDLE, act_o=0, pulse_o=0, err_o=0, count=0, origin/start/end=0.
REQ-032 After reset release, an enable_i 0->1 edge is required to start; enable already high at release does not start.

Verification
REQ-033 DIR=0, START=100, STEP=50, WIDTH=10, NUM=3, DELTAP=0; posn ramps 0->300 by 1/clk -> pulses high for posn 100-109, 150-159, 200-209 (+1 clk); act_o falls after posn=210.
REQ-034 RELATIVE=1, posn=1000 at enable rise, START=20, WIDTH=5, NUM=1 -> single pulse for posn 1020-1024.
REQ-035 DIR=1, START=-100, STEP=20, WIDTH=5, NUM=2, posn ramps 0 down -> pulses at -100..-104, -120..-124.
REQ-036 DELTAP=10, START=100, posn starts at 95 rising -> no pulse until posn dips to <=90, then pulse at 100.
REQ-037 WIDTH=3, posn jumps 99->110 -> err_o=1, act_o=0, pulse_o never high; cleared at next enable rise.
REQ-038 enable_i dropped mid-pulse, and separately reset_i=0 mid-run -> pulse_o=0, act_o=0 next clock (reset: immediately).
